// File: rtl/shift_sched.sv
// shift_sched: round-robin sequencer that runs 0..7 position shift jobs from
// two requesters through a shared 4-bit shifter limited to 2 positions/pass.
module shift_sched #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_id,
  output logic             busy,
  output logic [WIDTH-1:0] sh_a,
  output logic [1:0]       sh_amt,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             id_q, id_d;
  // rr_q names the requester that wins the next contention
  logic             rr_q, rr_d;

  logic             idle_s;
  logic             hs0_s, hs1_s;
  logic [1:0]       step_s;

  // Grant logic: a lone valid wins, contention goes to the round-robin favourite
  always_comb begin
    idle_s     = (state_q == IDLE);
    req0_ready = idle_s && req0_valid && (!req1_valid || (rr_q == 1'b0));
    req1_ready = idle_s && req1_valid && (!req0_valid || (rr_q == 1'b1));
    hs0_s      = req0_valid && req0_ready;
    hs1_s      = req1_valid && req1_ready;
    step_s     = (rem_q >= AMT_W'(2)) ? 2'd2 : 2'd1;
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (hs0_s) begin
          acc_d   = req0_a;
          rem_d   = req0_amt;
          dir_d   = req0_dir;
          id_d    = 1'b0;
          rr_d    = 1'b1;
          state_d = (req0_amt == AMT_W'(0)) ? DONE : SHIFT;
        end else if (hs1_s) begin
          acc_d   = req1_a;
          rem_d   = req1_amt;
          dir_d   = req1_dir;
          id_d    = 1'b1;
          rr_d    = 1'b0;
          state_d = (req1_amt == AMT_W'(0)) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // One shifter pass per cycle; no early exit when acc reaches zero
        acc_d = sh_y;
        rem_d = rem_q - AMT_W'(step_s);
        if (rem_d == AMT_W'(0)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        // Drain cycle never overlaps an accept: IDLE is entered first
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; a reset drops any job
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  // Outputs decoded purely from registered state, so they are glitch-free
  always_comb begin
    busy      = (state_q != IDLE);
    sh_a      = acc_q;
    sh_dir    = dir_q;
    sh_amt    = (state_q == SHIFT) ? step_s : 2'd0;
    rsp_valid = (state_q == DONE);
    rsp_y     = (state_q == DONE) ? acc_q : '0;
    rsp_id    = (state_q == DONE) ? id_q : 1'b0;
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed testbench for shift_sched with a behavioural shifter model.
`timescale 1ns/1ps
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_dir;
  logic [3:0] req0_a;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [3:0] req1_a;
  logic [2:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_y;
  logic [3:0] sh_a, sh_y;
  logic [1:0] sh_amt;
  logic       sh_dir;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Logical shifter as attached in the real system
  assign sh_y = sh_dir ? (sh_a >> sh_amt) : (sh_a << sh_amt);

  shift_sched #(.WIDTH(4), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy), .sh_a(sh_a), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_y(sh_y)
  );

  // Both readies must never be high together
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (req0_ready && req1_ready) begin
        bad++;
        $display("FAIL both_ready: req0_ready=%b req1_ready=%b required not both 1", req0_ready, req1_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 4'd0; req0_amt = 3'd0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_amt = 3'd0; req1_dir = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one job from requester rid with the other requester idle, then drain
  task automatic run_job(input logic rid, input logic [3:0] a, input logic [2:0] amt,
                         input logic d, input logic [3:0] exp_y, input string nm);
    int cyc;
    int lat;
    logic [3:0] m_acc;
    logic [2:0] m_rem;
    logic [1:0] m_step;
    lat = 1 + (int'(amt) + 1) / 2;
    if (rid == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_amt = amt; req0_dir = d;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_amt = amt; req1_dir = d;
    end
    #1;
    total++;
    if ((rid == 1'b0 ? req0_ready : req1_ready) !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got 0 required 1", nm);
    end
    total++;
    if (sh_amt !== 2'd0) begin
      bad++;
      $display("FAIL %s_idle_sh_amt: got %b required 00", nm, sh_amt);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    // scramble request fields: the job in flight must not see them
    req0_a = 4'b0110; req0_amt = 3'd5; req0_dir = ~d;
    req1_a = 4'b0110; req1_amt = 3'd5; req1_dir = ~d;
    cyc = 1;
    m_acc = a;
    m_rem = amt;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      m_step = (m_rem >= 3'd2) ? 2'd2 : 2'd1;
      total++;
      if (sh_amt !== m_step || sh_a !== m_acc || sh_dir !== d) begin
        bad++;
        $display("FAIL %s_pass%0d: got amt=%b a=%b dir=%b required amt=%b a=%b dir=%b",
                 nm, cyc, sh_amt, sh_a, sh_dir, m_step, m_acc, d);
      end
      m_acc = d ? (m_acc >> m_step) : (m_acc << m_step);
      m_rem = m_rem - {1'b0, m_step};
      tick();
      cyc++;
    end
    total++;
    if (cyc !== lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d required %0d", nm, cyc, lat);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_id !== rid || busy !== 1'b1 || sh_amt !== 2'd0) begin
      bad++;
      $display("FAIL %s_rsp: got v=%b y=%b id=%b busy=%b sh_amt=%b required v=1 y=%b id=%b busy=1 sh_amt=00",
               nm, rsp_valid, rsp_y, rsp_id, busy, sh_amt, exp_y, rid);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: got v=%b busy=%b required v=0 busy=0", nm, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rsp_valid, rsp_y, rsp_id, busy, sh_a, sh_amt, sh_dir, req0_ready, req1_ready} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b y=%b id=%b busy=%b sh_a=%b sh_amt=%b sh_dir=%b r0=%b r1=%b required all 0",
               rsp_valid, rsp_y, rsp_id, busy, sh_a, sh_amt, sh_dir, req0_ready, req1_ready);
    end
  endtask

  task automatic test_shifts();
    run_job(1'b0, 4'b1011, 3'd3, 1'b0, 4'b1000, "left3");
    run_job(1'b1, 4'b1011, 3'd1, 1'b1, 4'b0101, "right1");
    run_job(1'b0, 4'b1010, 3'd0, 1'b0, 4'b1010, "zero");
    run_job(1'b0, 4'b1111, 3'd7, 1'b0, 4'b0000, "max7");
    run_job(1'b1, 4'b1100, 3'd2, 1'b1, 4'b0011, "right2");
  endtask

  // Wait for a response and check it, bounded
  task automatic wait_rsp(input logic [3:0] exp_y, input logic exp_id, input string nm);
    int cyc;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_id !== exp_id) begin
      bad++;
      $display("FAIL %s: got v=%b y=%b id=%b required v=1 y=%b id=%b",
               nm, rsp_valid, rsp_y, rsp_id, exp_y, exp_id);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_a = 4'b0001; req0_amt = 3'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_a = 4'b1000; req1_amt = 3'd1; req1_dir = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL cont_first: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    wait_rsp(4'b0010, 1'b0, "cont_rsp0");
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL cont_drain_ready: got r1=%b required 0", req1_ready);
    end
    tick();
    rsp_ready = 1'b0;
    total++;
    if (req1_ready !== 1'b1) begin
      bad++;
      $display("FAIL cont_second: got r1=%b required 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_rsp(4'b0100, 1'b1, "cont_rsp1");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b0011; req0_amt = 3'd2; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_a = 4'b0011; req1_amt = 3'd2; req1_dir = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL cont_alternate: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(4'b1100, 1'b0, "cont_rsp2");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1'b1; req0_a = 4'b0110; req0_amt = 3'd2; req0_dir = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'b0011; req1_amt = 3'd1; req1_dir = 1'b0;
    wait_rsp(4'b0001, 1'b0, "bp_rsp");
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_y !== 4'b0001 || rsp_id !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b y=%b id=%b r1=%b required v=1 y=0001 id=0 r1=0",
                 i, rsp_valid, rsp_y, rsp_id, req1_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain_ready: got r1=%b required 0", req1_ready);
    end
    tick();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept: got v=%b r1=%b required v=0 r1=1", rsp_valid, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_rsp(4'b0110, 1'b1, "bp_rsp1");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midjob();
    do_reset();
    req0_valid = 1'b1; req0_a = 4'b1111; req0_amt = 3'd6; req0_dir = 1'b1;
    tick();
    req0_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || sh_amt !== 2'd2) begin
      bad++;
      $display("FAIL mid_shift: got busy=%b sh_amt=%b required busy=1 sh_amt=10", busy, sh_amt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({rsp_valid, rsp_y, rsp_id, busy, sh_a, sh_amt, sh_dir, req0_ready, req1_ready} !== 17'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got v=%b y=%b id=%b busy=%b sh_a=%b sh_amt=%b sh_dir=%b required all 0",
               rsp_valid, rsp_y, rsp_id, busy, sh_a, sh_amt, sh_dir);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_rsp%0d: got v=%b busy=%b required 0 0", i, rsp_valid, busy);
      end
      tick();
    end
    run_job(1'b0, 4'b0101, 3'd1, 1'b0, 4'b1010, "post_reset");
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_contention();
    test_backpressure();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
Sequencing and arbitration controller for the shared 4-bit barrel shifter. The shifter moves at most 2 positions per pass. This block accepts shift jobs of 0..7 positions from two requesters, arbitrates round-robin, and iterates the shifter over several passes. It returns the result on a valid/ready response channel tagged with the requester id. It sits between the ALU issue logic and the shifter instance, and drives the shifter's A/amt/dir inputs directly.

Parameters:
WIDTH, 4, data width; fixed to the shifter width; other values unsupported.
AMT_W, 3, request shift-amount width; max amount 2**AMT_W-1 = 7.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  reset; synchronous, active-low.
req0_valid  input  1  requester 0 has a job.
req0_ready  output  1  requester 0 job accepted this cycle.
req0_a  input  WIDTH  requester 0 operand.
req0_amt  input  AMT_W  requester 0 shift amount.
req0_dir  input  1  requester 0 direction; 0 = left, 1 = right.
req1_valid, req1_ready, req1_a, req1_amt, req1_dir  same as requester 0, for requester 1.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes result.
rsp_y  output  WIDTH  shifted result.
rsp_id  output  1  requester that owns the result.
busy  output  1  high when state != IDLE.
sh_a  output  WIDTH  shifter operand.
sh_amt  output  2  shifter amount per pass; only 00, 01 or 10 are ever driven.
sh_dir  output  1  shifter direction.
sh_y  input  WIDTH  shifter combinational result.

Behaviour:
- Reset (rst_n low at edge):
  - state = IDLE; acc, rem, id, dir regs = 0.
  - Round-robin pointer favours requester 0.
  - All outputs 0: rsp_valid, rsp_y, rsp_id, busy, sh_a, sh_amt, sh_dir, reqN_ready.
  - Reset mid-job drops the job silently; no response is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester not granted last; the first contention after reset goes to requester 0.
  - reqN_ready is combinational: high only in IDLE for the granted requester, in the same cycle as its valid.
  - Handshake = valid & ready. On handshake: acc <= a, rem <= amt, dir <= dir, id <= N; pointer updated.
  - Next state: DONE if amt == 0, else SHIFT.
  - reqN_ready is 0 in SHIFT and DONE.
- SHIFT (one pass per cycle):
  - Drive sh_a = acc, sh_dir = dir, sh_amt = 2 if rem >= 2, else 1.
  - acc <= sh_y; rem <= rem - step.
  - When rem - step == 0, go to DONE.
  - Number of passes = ceil(amt/2). No early exit when acc becomes 0.
- Outside SHIFT: sh_amt = 00, sh_a = acc, sh_dir = dir. The shifter output is ignored.
- DONE:
  - rsp_valid = 1, rsp_y = acc, rsp_id = id.
  - These outputs are held stable while rsp_ready is low.
  - On rsp_ready high, go to IDLE; rsp_valid drops next cycle.
  - No new job is accepted in the same cycle as response drain; the earliest next accept is the following cycle in IDLE.
- Latency: handshake at cycle T, then rsp_valid at T+1+ceil(amt/2). Example: amt 3 gives rsp_valid at T+3; amt 0 gives T+1.
- Request inputs are sampled only at handshake. Changes afterwards have no effect on the job in flight.
- Bits shifted out are lost and fill bits are 0 (logical shift). Shifting by 4 or more positions yields 0000.
- busy = (state != IDLE).

Test Plan:
- Left shift: req0 a=1011, amt=3, dir=0 -> sh_amt 10 then 01; rsp_y=1000, rsp_id=0, rsp_valid at T+3.
- Right shift by 1 and zero amount:
  - req1 a=1011, amt=1, dir=1 -> rsp_y=0101 at T+2.
  - req0 a=1010, amt=0 -> rsp_y=1010 at T+1; sh_amt stays 00 throughout.
- Max amount: req0 a=1111, amt=7, dir=0 -> four passes (2,2,2,1); rsp_y=0000 at T+5.
- Contention: both valid from reset with distinct jobs -> req0 granted first, req1 granted after req0's response drains. Then with both valid again -> req0 granted (alternation holds). Never both ready in the same cycle.
- Backpressure: rsp_ready held low 5 cycles in DONE -> rsp_valid/rsp_y/rsp_id stable; req1_ready stays 0 despite req1_valid=1; req1 is accepted only after the drain cycle.
- Reset mid-job: rst_n low during SHIFT of amt=6 -> next cycle state IDLE, all outputs 0, no response for the dropped job, and a new req0 job is accepted normally.
